// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: depth derivation and
// width-generic binary/gray conversion (callers zero-extend in and truncate out).
package fifo_pkg;

  // Widest pointer any FIFO side may use (ADDR_W up to 12, plus wrap bit).
  localparam int unsigned PtrMaxW = 13;

  typedef logic [PtrMaxW-1:0] ptr_max_t;

  // Number of RAM entries for a given address width.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // XOR prefix from the MSB down; zero-extended upper bits stay zero.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = '0;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int i = int'(PtrMaxW) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/afifo_gray_ptr.sv
// Binary + gray pointer register with increment enable. The gray copy is
// registered so it can cross into the other clock domain glitch-free.
module afifo_gray_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned PtrW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  output logic [PtrW-1:0] bin_o,
  output logic [PtrW-1:0] gray_o
);

  logic [PtrW-1:0] bin_q, bin_d;
  logic [PtrW-1:0] gray_q, gray_d;

  // Next binary value wraps naturally at 2^PtrW; gray follows it.
  always_comb begin
    bin_d  = bin_q + PtrW'(inc_i);
    gray_d = PtrW'(bin2gray(ptr_max_t'(bin_d)));
  end

  // Pointer state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the async FIFO: request qualification, RAM write
// enable/address, gray write pointer, full/almost-full/level flags and a
// sticky overflow flag. Everything runs on wclk_i.
module afifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AF_THRESH = 2,
  parameter bit          EDGE_MODE = 1'b1
) (
  input  logic              wclk_i,
  input  logic              wrst_ni,
  input  logic              winc_i,
  input  logic [ADDR_W:0]   wq2_rptr_i,
  input  logic              wovf_clr_i,
  output logic [ADDR_W:0]   wptr_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic              wclken_o,
  output logic              wfull_o,
  output logic              walmost_full_o,
  output logic [ADDR_W:0]   wlevel_o,
  output logic              woverflow_o
);

  localparam int unsigned PtrW  = ADDR_W + 1;
  localparam int unsigned Depth = depth_of(ADDR_W);

  logic            winc_q;
  logic            req;
  logic            wclken;
  logic [PtrW-1:0] wbin, wgray;
  logic [PtrW-1:0] wbin_next, wgray_next;
  logic [PtrW-1:0] rbin, rptr_full;
  logic [PtrW-1:0] free_slots;
  logic            wfull_q, wfull_d;
  logic            af_q, af_d;
  logic [PtrW-1:0] level_q, level_d;
  logic            ovf_q, ovf_d;

  afifo_gray_ptr #(
    .PtrW (PtrW)
  ) u_wptr (
    .clk_i  (wclk_i),
    .rst_ni (wrst_ni),
    .inc_i  (wclken),
    .bin_o  (wbin),
    .gray_o (wgray)
  );

  // Request qualification and flag next-state from the post-write pointer.
  always_comb begin
    req        = EDGE_MODE ? (winc_i & ~winc_q) : winc_i;
    wclken     = req & ~wfull_q & wrst_ni;
    // Same value the pointer register loads on this edge.
    wbin_next  = wbin + PtrW'(wclken);
    wgray_next = PtrW'(bin2gray(ptr_max_t'(wbin_next)));
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    rptr_full  = {~wq2_rptr_i[ADDR_W:ADDR_W-1], wq2_rptr_i[ADDR_W-2:0]};
    wfull_d    = (wgray_next == rptr_full);
    rbin       = PtrW'(gray2bin(ptr_max_t'(wq2_rptr_i)));
    level_d    = wbin_next - rbin;
    free_slots = PtrW'(Depth) - level_d;
    af_d       = (free_slots <= PtrW'(AF_THRESH));
    // A new overflow outranks a simultaneous clear.
    ovf_d      = (req & wfull_q) | (ovf_q & ~wovf_clr_i);
  end

  // Edge-detect and flag registers, synchronous active-low reset.
  always_ff @(posedge wclk_i) begin
    if (!wrst_ni) begin
      winc_q  <= 1'b0;
      wfull_q <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      winc_q  <= winc_i;
      wfull_q <= wfull_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wptr_o         = wgray;
  assign waddr_o        = wbin[ADDR_W-1:0];
  assign wclken_o       = wclken;
  assign wfull_o        = wfull_q;
  assign walmost_full_o = af_q;
  assign wlevel_o       = level_q;
  assign woverflow_o    = ovf_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl: edge-mode instance for reset, fill,
// overflow and mid-run reset; level-mode instance for held-write wrap-around.
module tb_afifo_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Edge-mode instance
  logic       e_rst_n, e_winc, e_clr;
  logic [3:0] e_rptr;
  logic [3:0] e_wptr, e_lvl;
  logic [2:0] e_waddr;
  logic       e_wclken, e_wfull, e_af, e_ovf;

  // Level-mode instance
  logic       l_rst_n, l_winc, l_clr;
  logic [3:0] l_rptr;
  logic [3:0] l_wptr, l_lvl;
  logic [2:0] l_waddr;
  logic       l_wclken, l_wfull, l_af, l_ovf;

  afifo_wr_ctrl #(
    .ADDR_W    (3),
    .AF_THRESH (2),
    .EDGE_MODE (1'b1)
  ) u_edge (
    .wclk_i         (clk),
    .wrst_ni        (e_rst_n),
    .winc_i         (e_winc),
    .wq2_rptr_i     (e_rptr),
    .wovf_clr_i     (e_clr),
    .wptr_o         (e_wptr),
    .waddr_o        (e_waddr),
    .wclken_o       (e_wclken),
    .wfull_o        (e_wfull),
    .walmost_full_o (e_af),
    .wlevel_o       (e_lvl),
    .woverflow_o    (e_ovf)
  );

  afifo_wr_ctrl #(
    .ADDR_W    (3),
    .AF_THRESH (2),
    .EDGE_MODE (1'b0)
  ) u_lvl (
    .wclk_i         (clk),
    .wrst_ni        (l_rst_n),
    .winc_i         (l_winc),
    .wq2_rptr_i     (l_rptr),
    .wovf_clr_i     (l_clr),
    .wptr_o         (l_wptr),
    .waddr_o        (l_waddr),
    .wclken_o       (l_wclken),
    .wfull_o        (l_wfull),
    .walmost_full_o (l_af),
    .wlevel_o       (l_lvl),
    .woverflow_o    (l_ovf)
  );

  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e_pulse();
    e_winc = 1'b1;
    tick();
    e_winc = 1'b0;
    tick();
  endtask

  initial begin
    int         k;
    logic [3:0] wr, rd, m_lvl;
    logic       m_full, exp_en;

    e_rst_n = 1'b0; e_winc = 1'b1; e_clr = 1'b0; e_rptr = 4'h0;
    l_rst_n = 1'b0; l_winc = 1'b1; l_clr = 1'b0; l_rptr = 4'h0;
    tick();
    tick();

    // Reset state with winc held high
    chk("rst_wptr",   32'(e_wptr),   32'd0);
    chk("rst_waddr",  32'(e_waddr),  32'd0);
    chk("rst_wclken", 32'(e_wclken), 32'd0);
    chk("rst_wfull",  32'(e_wfull),  32'd0);
    chk("rst_af",     32'(e_af),     32'd0);
    chk("rst_lvl",    32'(e_lvl),    32'd0);
    chk("rst_ovf",    32'(e_ovf),    32'd0);
    chk("rst_l_wclken", 32'(l_wclken), 32'd0);

    // Release: exactly one write from the held winc
    e_rst_n = 1'b1;
    #1;
    chk("rel_wclken", 32'(e_wclken), 32'd1);
    chk("rel_waddr",  32'(e_waddr),  32'd0);
    tick();
    chk("rel_wptr",    32'(e_wptr),   32'h1);
    chk("rel_waddr1",  32'(e_waddr),  32'd1);
    chk("rel_lvl",     32'(e_lvl),    32'd1);
    chk("rel_wclken2", 32'(e_wclken), 32'd0);
    tick();
    chk("rel_wclken3", 32'(e_wclken), 32'd0);
    chk("rel_wptr2",   32'(e_wptr),   32'h1);

    // Fill 8 entries from empty
    e_winc = 1'b0; e_rst_n = 1'b0;
    tick();
    e_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      e_winc = 1'b1;
      #1;
      chk("fill_wclken", 32'(e_wclken), 32'd1);
      chk("fill_waddr",  32'(e_waddr),  32'(i));
      tick();
      e_winc = 1'b0;
      k = i + 1;
      chk("fill_lvl",   32'(e_lvl),   32'(k));
      chk("fill_wptr",  32'(e_wptr),  32'(gray_tbl[k]));
      chk("fill_af",    32'(e_af),    32'((k >= 6) ? 1 : 0));
      chk("fill_wfull", 32'(e_wfull), 32'((k == 8) ? 1 : 0));
      tick();
    end

    // Write attempt while full
    e_winc = 1'b1;
    #1;
    chk("ovf_wclken", 32'(e_wclken), 32'd0);
    tick();
    chk("ovf_wptr", 32'(e_wptr), 32'hc);
    chk("ovf_set",  32'(e_ovf),  32'd1);
    chk("ovf_lvl",  32'(e_lvl),  32'd8);
    e_winc = 1'b0;
    tick();
    chk("ovf_sticky", 32'(e_ovf), 32'd1);
    // Set and clear in the same cycle: set wins
    e_winc = 1'b1; e_clr = 1'b1;
    tick();
    chk("ovf_setwins", 32'(e_ovf), 32'd1);
    e_winc = 1'b0;
    tick();
    chk("ovf_clr", 32'(e_ovf), 32'd0);
    e_clr = 1'b0;

    // Read pointer moves one slot: full drops next edge
    e_rptr = 4'h1;
    tick();
    chk("rd_wfull", 32'(e_wfull), 32'd0);
    chk("rd_lvl",   32'(e_lvl),   32'd7);
    chk("rd_af",    32'(e_af),    32'd1);

    // Mid-operation reset after 5 writes
    e_rst_n = 1'b0; e_rptr = 4'h0;
    tick();
    e_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) e_pulse();
    chk("mid_lvl",  32'(e_lvl),  32'd5);
    chk("mid_wptr", 32'(e_wptr), 32'h7);
    e_winc = 1'b1; e_rst_n = 1'b0;
    #1;
    chk("mid_wclken_rst", 32'(e_wclken), 32'd0);
    tick();
    chk("mid_wptr0",  32'(e_wptr),  32'd0);
    chk("mid_lvl0",   32'(e_lvl),   32'd0);
    chk("mid_wfull0", 32'(e_wfull), 32'd0);
    chk("mid_waddr0", 32'(e_waddr), 32'd0);
    e_rst_n = 1'b1; e_winc = 1'b0;
    #1;
    chk("mid_wclken_rel", 32'(e_wclken), 32'd0);
    tick();
    chk("mid_wptr_hold", 32'(e_wptr), 32'd0);

    // Level mode: winc held, read pointer advances every 2 cycles
    l_rst_n = 1'b1;
    wr = 4'h0; rd = 4'h0; m_full = 1'b0;
    for (int c = 0; c < 24; c++) begin
      l_rptr = gray_tbl[rd];
      #1;
      exp_en = ~m_full;
      chk("lvl_wclken", 32'(l_wclken), 32'(exp_en));
      if (exp_en) wr = wr + 4'd1;
      tick();
      m_lvl  = wr - rd;
      m_full = (m_lvl == 4'd8);
      chk("lvl_level", 32'(l_lvl),   32'(m_lvl));
      chk("lvl_wfull", 32'(l_wfull), 32'(m_full));
      chk("lvl_wptr",  32'(l_wptr),  32'(gray_tbl[wr]));
      if (c % 2 == 1) rd = rd + 4'd1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
